// File: rtl/rotary_cursor.sv
// rotary_cursor: rotary-encoder and push-button front end for the tic-tac-toe board.
// Synchronizes and debounces the raw A/B/centre inputs, decodes quadrature detents
// into a 0..9 board cursor, and produces a debounced press level plus a select strobe.
// Optional feature: define ROTARY_CURSOR_WRAP_EN to make the cursor wrap 9<->1
// instead of saturating at the ends.
module rotary_cursor #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rot_a,
    input  logic       rot_b,
    input  logic       rot_ctr,
    output logic [7:0] square_num,
    output logic       rotctr_debounce,
    output logic       select_pulse,
    output logic       step_cw,
    output logic       step_ccw
);

    // Channel index into the packed input vectors
    localparam int CH_A   = 0;
    localparam int CH_B   = 1;
    localparam int CH_CTR = 2;
    localparam int N_CH   = 3;

    localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]  sync_p0;
    logic [N_CH-1:0]  sync_p1;
    logic [CNT_W-1:0] db_cnt [N_CH];
    logic [N_CH-1:0]  db_stb;
    logic             a_prev;
    logic             ctr_prev;
    logic [3:0]       cursor;

    logic             a_rise;
    logic             ctr_rise;
    logic             press_fire;

    // Next cursor value for a clockwise detent; wrap or saturate at 9
    function automatic logic [3:0] cw_next(input logic [3:0] s);
        logic [3:0] r;
        if (s >= 4'd9) begin
`ifdef ROTARY_CURSOR_WRAP_EN
            r = 4'd1;
`else
            r = 4'd9;
`endif
        end else begin
            r = s + 4'd1;
        end
        return r;
    endfunction

    // Next cursor value for a counter-clockwise detent; 0 and 1 both map to the low end
    function automatic logic [3:0] ccw_next(input logic [3:0] s);
        logic [3:0] r;
        if (s <= 4'd1) begin
`ifdef ROTARY_CURSOR_WRAP_EN
            r = 4'd9;
`else
            r = 4'd1;
`endif
        end else begin
            r = s - 4'd1;
        end
        return r;
    endfunction

    // Two-flop synchronizer for the three asynchronous raw inputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {rot_ctr, rot_b, rot_a};
            sync_p1 <= sync_p0;
        end
    end

    // Per-channel debouncer: level only changes after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            db_stb <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync_p1[i] == db_stb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_TERM) begin
                    db_stb[i] <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge detection on the debounced A and centre levels
    assign a_rise     = db_stb[CH_A] & ~a_prev;
    assign ctr_rise   = db_stb[CH_CTR] & ~ctr_prev;
    // A press only "wins" over a simultaneous step when it actually produces a select
    assign press_fire = ctr_rise & (cursor != 4'd0);

    // Edge history; always advances so a discarded step is never replayed later
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a_prev   <= 1'b0;
            ctr_prev <= 1'b0;
        end else begin
            a_prev   <= db_stb[CH_A];
            ctr_prev <= db_stb[CH_CTR];
        end
    end

    // Cursor update and output strobes; press has priority over a same-cycle step
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cursor       <= 4'd0;
            select_pulse <= 1'b0;
            step_cw      <= 1'b0;
            step_ccw     <= 1'b0;
        end else begin
            select_pulse <= press_fire;
            step_cw      <= a_rise & ~db_stb[CH_B] & ~press_fire;
            step_ccw     <= a_rise &  db_stb[CH_B] & ~press_fire;
            if (a_rise && !press_fire) begin
                cursor <= db_stb[CH_B] ? ccw_next(cursor) : cw_next(cursor);
            end
        end
    end

    assign square_num      = {4'd0, cursor};
    assign rotctr_debounce = db_stb[CH_CTR];

endmodule

// File: doc/rotary_cursor.md
# rotary_cursor

Front-end input stage for the tic-tac-toe board. It synchronizes and debounces the raw rotary-encoder A/B channels and centre push-button, and decodes quadrature steps into a board cursor, `square_num` (0 = no square, 1–9 = board squares). It also produces the debounced press level and a one-cycle select strobe. Its outputs drive the board-logic stage, which uses `square_num` for cursor highlighting and the press signal to place marks.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz).
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  system clock.
- `clr`  in  1  reset, asynchronous, active-high.
- `rot_a`  in  1  raw encoder channel A, asynchronous to `clk`.
- `rot_b`  in  1  raw encoder channel B, asynchronous to `clk`.
- `rot_ctr`  in  1  raw centre push-button, active-high, asynchronous to `clk`.
- `square_num`  out  8  registered cursor value, range 0–9; bits [7:4] always 0.
- `rotctr_debounce`  out  1  registered debounced push-button level.
- `select_pulse`  out  1  one-cycle strobe on a debounced press while `square_num != 0`.
- `step_cw`  out  1  one-cycle strobe per clockwise detent.
- `step_ccw`  out  1  one-cycle strobe per counter-clockwise detent.

## Operation
- **Synchronizer:** each raw input passes through a 2-flop synchronizer. Sync flops reset to 0.
- **Debouncer (one per input):** keeps a stable level and a counter.
  - If sync value == stable: counter clears to 0.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, stable takes the sync value and the counter clears.
  - Any return to the stable value before terminal count clears the counter, so no level change occurs.
- **Quadrature decode:** acts on the rising edge of debounced A (current high, previous low).
  - Debounced B == 0: clockwise step, `step_cw` = 1.
  - Debounced B == 1: counter-clockwise step, `step_ccw` = 1.
  - A falling edge and any B edge generate no step.
- **Cursor update** (`square_num`, registered):
  - CW from 0 → 1; CW from 1–8 → +1; CW from 9 → see Configuration.
  - CCW from 0 → 9 with wrap, or 1 without wrap; CCW from 2–9 → −1; CCW from 1 → see Configuration.
- **Press handling:**
  - Rising edge of debounced `rot_ctr` with `square_num` in 1–9: `select_pulse` = 1 for exactly one cycle.
  - Press edge with `square_num == 0`: no pulse.
  - `rotctr_debounce` follows the debounced level regardless of cursor value.
- **Simultaneous press edge and step in the same cycle:** the press wins. `select_pulse` fires, the step is discarded (no `step_*` strobe, no cursor change), and `square_num` is stable during the strobe.
- **Holding the button:** generates exactly one `select_pulse`; release generates none.
- **Reset mid-operation:** every register (sync, debounce counters, stable levels, edge history, cursor, strobes) returns to 0 immediately. A partially counted bounce is discarded.

## Timing
- Reset values: `square_num` = 0, `rotctr_debounce` = 0, `select_pulse` = 0, `step_cw` = 0, `step_ccw` = 0.
- Raw edge to debounced level change: 2 (sync) + `DEBOUNCE_CYCLES` cycles.
- Debounced A edge to `step_*` strobe and `square_num` update: 1 cycle. Both change on the same `clk` edge.
- Debounced `rot_ctr` edge to `select_pulse`: 1 cycle. Pulse width is exactly 1 cycle.
- Maximum step rate: one step per `2*DEBOUNCE_CYCLES` cycles. Faster rotation is filtered out, not queued.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `ROTARY_CURSOR_WRAP_EN`.
- **Defined:** cursor wraps. CW from 9 → 1, CCW from 1 → 9, CCW from 0 → 9. The `step_*` strobe is still issued on a wrap.
- **Undefined:** cursor saturates. CW at 9 stays 9, CCW at 1 stays 1, CCW from 0 → 1. The `step_*` strobe is still issued even when the value does not change.

## Test plan
Bench uses `DEBOUNCE_CYCLES=4`.
- **Reset:** assert `clr` mid-count, with `rot_a` high for 3 cycles → all outputs 0 and no step after deassert until A is held a fresh 4 cycles.
- **Bounce rejection:** toggle `rot_ctr` 1,0,1,0 every 2 cycles → `rotctr_debounce` stays 0 and `select_pulse` never asserts.
- **Rotation sequence:** 3 clean CW detents (B=0 at A rise) from reset → `square_num` 1,2,3 and three `step_cw` strobes. Then 1 CCW detent → 2.
- **Wrap vs saturate:** from 9, one CW detent → 1 with `ROTARY_CURSOR_WRAP_EN` defined, 9 without. From 1, one CCW detent → 9 or 1 respectively.
- **Press behaviour:** press at `square_num` = 5, held 50 cycles → exactly one `select_pulse` with `square_num` = 5 and `rotctr_debounce` high for the hold. Press at `square_num` = 0 → no pulse.
- **Simultaneous events:** debounced press edge and A rise in the same cycle at `square_num` = 4 → `select_pulse` = 1, no `step_*` strobe, `square_num` stays 4.
